// File: rtl/dac_sample_feeder.sv
// Sample FIFO and rate adapter feeding the sigma-delta DAC; holds the last sample on underrun.
// Optional saturating underrun counter is built when DAC_FEEDER_UNDERRUN_CNT_EN is defined.
module dac_sample_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          dac_ready,
  output logic [DATA_WIDTH-1:0]         dac_input,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          running,
  output logic                          underrun,
  output logic [15:0]                   underrun_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_THRES = LW'(PRIME_LEVEL);

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] dac_q, dac_d;
  logic                  underrun_q, underrun_d;
  logic                  push_s;
  logic                  pop_s;

  // Ready comes only from the registered occupancy, so a write is never dropped.
  assign s_ready = (level_q != FULL_LEVEL);
  assign push_s  = s_valid & s_ready;

  // Next-state, pop and underrun decisions; dac_ready is only honoured in RUN.
  always_comb begin
    state_d    = state_q;
    pop_s      = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      PRIME: begin
        if (level_q >= PRIME_THRES) begin
          state_d = RUN;
        end else begin
          state_d = PRIME;
        end
      end
      RUN: begin
        if (dac_ready) begin
          if (level_q != {LW{1'b0}}) begin
            pop_s = 1'b1;
          end else begin
            underrun_d = 1'b1;
            state_d    = PRIME;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = PRIME;
      end
    endcase
  end

  // Pointer, occupancy and output-sample next values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dac_d    = dac_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dac_d    = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      dac_d    = dac_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PRIME;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      dac_q      <= MIDSCALE;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  // Saturating count of underrun events, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt_q <= 16'h0000;
    end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_count = underrun_cnt_q;
`else
  assign underrun_count = 16'h0000;
`endif

  assign dac_input = dac_q;
  assign level     = level_q;
  assign running   = (state_q == RUN);
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed self-checking bench for dac_sample_feeder with a sample scoreboard queue.
module tb_dac_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        dac_ready;
  logic [15:0] dac_input;
  logic [4:0]  level;
  logic        running;
  logic        underrun;
  logic [15:0] underrun_count;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_s;

`ifdef DAC_FEEDER_UNDERRUN_CNT_EN
  localparam int CNT_STEP = 1;
`else
  localparam int CNT_STEP = 0;
`endif

  dac_sample_feeder dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dac_ready(dac_ready), .dac_input(dac_input), .level(level), .running(running),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then sit on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    dac_ready = 1'b1;
    step();
    dac_ready = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      last_s = exp_q.pop_front();
      chk(tag, dac_input, last_s);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; s_data = 16'h0000; s_valid = 1'b0; dac_ready = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    chk("rst_dac", dac_input, 16'h8000);
    chk("rst_running", running, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_level", level, 5'd0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_count", underrun_count, 16'h0000);

    // Idle dac_ready pulses while priming are ignored.
    for (int i = 0; i < 4; i++) begin
      dac_ready = 1'b1;
      step();
      dac_ready = 1'b0;
      chk("idle_dac", dac_input, 16'h8000);
      chk("idle_running", running, 1'b0);
      chk("idle_underrun", underrun, 1'b0);
      step();
    end

    // Prime with 1..8.
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      exp_q.push_back(16'(i));
      step();
    end
    s_valid = 1'b0;
    chk("prime_level", level, 5'd8);
    chk("prime_not_yet_running", running, 1'b0);
    step();
    chk("prime_running", running, 1'b1);

    for (int i = 0; i < 8; i++) pop_check("pop_order");
    chk("drain_level", level, 5'd0);
    chk("drain_running", running, 1'b1);

    // Underrun on empty dac_ready.
    dac_ready = 1'b1;
    step();
    dac_ready = 1'b0;
    chk("ur_pulse", underrun, 1'b1);
    chk("ur_running", running, 1'b0);
    chk("ur_dac_hold", dac_input, 16'h0008);
    chk("ur_count", underrun_count, 16'(CNT_STEP));
    step();
    chk("ur_pulse_end", underrun, 1'b0);

    // Fill to full, then hold off a 17th sample.
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 16'h0100 + 16'(i);
      exp_q.push_back(16'h0100 + 16'(i));
      step();
    end
    s_data = 16'hDEAD;
    chk("full_level", level, 5'd16);
    chk("full_s_ready", s_ready, 1'b0);
    step();
    chk("full_held_level", level, 5'd16);
    dac_ready = 1'b1;
    step();
    dac_ready = 1'b0;
    last_s = exp_q.pop_front();
    chk("full_pop_dac", dac_input, last_s);
    chk("full_pop_s_ready", s_ready, 1'b1);
    chk("full_pop_level", level, 5'd15);
    s_valid = 1'b0;
    step();

    for (int i = 0; i < 15; i++) pop_check("pop_full_order");
    chk("drain2_level", level, 5'd0);

    // Simultaneous push and dac_ready at empty: underrun, sample stored not bypassed.
    s_valid = 1'b1; s_data = 16'hABCD; dac_ready = 1'b1;
    step();
    s_valid = 1'b0; dac_ready = 1'b0;
    chk("sim_underrun", underrun, 1'b1);
    chk("sim_level", level, 5'd1);
    chk("sim_running", running, 1'b0);
    chk("sim_dac_hold", dac_input, 16'h010F);
    chk("sim_count", underrun_count, 16'(2 * CNT_STEP));

    // Reset mid-stream at level 5.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 16'h0200 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    chk("mid_level", level, 5'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_level", level, 5'd0);
    chk("mrst_dac", dac_input, 16'h8000);
    chk("mrst_running", running, 1'b0);
    chk("mrst_count", underrun_count, 16'h0000);
    chk("mrst_s_ready", s_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Sample buffer and rate adapter sitting directly upstream of the sigma-delta DAC. Accepts samples from a valid/ready source at any rate and stores them in a FIFO. Presents one held sample on `dac_input`, advancing only on the DAC's one-cycle `dac_ready` pulse (once per oversample period). Primes the FIFO before starting, and on underrun holds the last sample rather than glitching.

## Interface
Parameters:
- `DATA_WIDTH`, 16, sample width; offset-binary, matches the DAC input width.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥4.
- `PRIME_LEVEL`, 8, fill level required to enter/re-enter RUN; 1..`FIFO_DEPTH`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `s_data`  in  `DATA_WIDTH`  input sample.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  FIFO can accept a sample.
- `dac_ready`  in  1  one-cycle pulse from the DAC, once per oversample period.
- `dac_input`  out  `DATA_WIDTH`  held sample to the DAC.
- `level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.
- `running`  out  1  high in RUN state.
- `underrun`  out  1  one-cycle pulse on underrun.
- `underrun_count`  out  16  saturating underrun count (see Configuration).

## Operation
- FIFO: circular buffer with `FIFO_DEPTH` entries. Read and write pointers wrap modulo `FIFO_DEPTH`. `level` is a registered occupancy count.
- Push: `s_valid && s_ready`. `s_ready = (level != FIFO_DEPTH)`, derived from registered `level`. No write can ever be dropped.
- State machine, two states:
  - PRIME:
    - No pops; `dac_input` held.
    - When `level >= PRIME_LEVEL` (registered `level`), go to RUN next cycle.
    - `dac_ready` is ignored in PRIME.
  - RUN, on `dac_ready`:
    - If `level != 0`: pop the head into the `dac_input` register.
    - If `level == 0`: underrun. `dac_input` holds, `underrun` pulses, state returns to PRIME.
- Simultaneous push and pop: `level` is unchanged and both pointers advance.
- Push and `dac_ready` in the same cycle with `level == 0` in RUN: this is an underrun. The pushed sample is stored (`level` becomes 1) and is not bypassed to the output.
- `level` arithmetic: +1 on push only, −1 on pop only, unchanged otherwise. It never exceeds `FIFO_DEPTH` and never goes below 0.

## Timing
- Reset values:
  - state = PRIME
  - `level` = 0, pointers = 0
  - `s_ready` = 1
  - `dac_input` = midscale, `1 << (DATA_WIDTH-1)`
  - `running` = 0, `underrun` = 0, `underrun_count` = 0
- Push latency: `level` increments the cycle after the handshake.
- PRIME→RUN: `running` rises 1 cycle after `level` first reads ≥ `PRIME_LEVEL`.
- Pop: `dac_input` updates 1 cycle after `dac_ready`. The DAC latches on its next `dac_ready`, so the sample-to-DAC latency is one sample period.
- Underrun: `underrun` is high for exactly 1 cycle, the cycle after the empty `dac_ready`. `running` falls the same cycle.
- `rst` asserted mid-operation: on the next edge, all state returns to the reset values and FIFO contents are discarded. `dac_input` returns to midscale.
- `dac_ready` asserted for multiple consecutive cycles: each cycle counts as a separate pop request. This is legal but does not occur with the DAC.

## Configuration
- `DAC_FEEDER_UNDERRUN_CNT_EN` defined:
  - `underrun_count` increments on every `underrun` pulse.
  - It saturates at 16'hFFFF and is cleared only by `rst`.
- `DAC_FEEDER_UNDERRUN_CNT_EN` undefined:
  - The counter logic is not built.
  - `underrun_count` is tied to 0. The port is still present, so instantiations do not change.

## Test plan
- Reset, no input, 4 `dac_ready` pulses → `dac_input` stays 16'h8000, `running` = 0, `underrun` never asserted.
- Push 8 samples 16'h0001..16'h0008 back-to-back (`PRIME_LEVEL` = 8) → `running` rises 1 cycle after `level` reads 8. Subsequent `dac_ready` pulses produce `dac_input` = 1, 2, …, 8 in order, each 1 cycle after its pulse.
- Hold `s_valid` high until full (16 pushes, no `dac_ready`) → `s_ready` = 0 with `level` = 16, and the 17th sample is held off. Then one `dac_ready` → `s_ready` = 1 the next cycle.
- In RUN, drain to `level` = 0, then one more `dac_ready` → `underrun` pulses once, `running` = 0, `dac_input` holds the last sample. `underrun_count` = 1 with the macro defined, 0 without.
- Push and `dac_ready` in the same cycle at `level` = 0 in RUN → underrun declared, `level` = 1, state PRIME, `dac_input` unchanged.
- Assert `rst` mid-stream with `level` = 5 → next cycle `level` = 0, `dac_input` = 16'h8000, `running` = 0, `underrun_count` = 0.
